// File: rtl/rtype_pkg.sv
// rtype_pkg: shared constants, FSM state type and R-type field extractors
package rtype_pkg;
    localparam int XLEN = 32;
    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    function automatic logic [4:0] f_rd(input logic [XLEN-1:0] w);
        return w[11:7];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [XLEN-1:0] w);
        return w[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [XLEN-1:0] w);
        return w[24:20];
    endfunction
endpackage

// File: rtl/rtype_regfile.sv
// rtype_regfile: 32-entry register file, two operand reads, one debug read, one shared write port
module rtype_regfile #(
    parameter int XLEN = rtype_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      dra,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] drd,
    input  logic            wb_we,
    input  logic [4:0]      wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_waddr,
    input  logic [XLEN-1:0] dbg_wdata
);
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;

    assign rd1 = (ra1 == 5'd0) ? '0 : rf_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : rf_q[ra2];
    assign drd = (dra == 5'd0) ? '0 : rf_q[dra];

    // writeback has priority on the shared port; x0 is never written
    always_comb begin
        we    = wb_we | dbg_we;
        waddr = wb_we ? wb_waddr : dbg_waddr;
        wdata = wb_we ? wb_wdata : dbg_wdata;
        rf_d  = rf_q;
        if (we && waddr != 5'd0) rf_d[waddr] = wdata;
    end

    // register storage with synchronous clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) rf_q[i] <= reset ? '0 : rf_d[i];
    end
endmodule

// File: rtl/rtype_issue.sv
// rtype_issue: issue/writeback sequencer driving a combinational R-type execution unit
module rtype_issue #(
    parameter int XLEN = rtype_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [XLEN-1:0] instr_word,
    output logic [XLEN-1:0] alu_instr,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_waddr,
    input  logic [XLEN-1:0] dbg_wdata,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);
    import rtype_pkg::*;

    state_t          state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] rd1, rd2;
    logic            accept, in_exec;

    assign accept      = instr_valid && instr_ready;
    assign in_exec     = state_q == EXEC;
    assign instr_ready = state_q == IDLE && !reset;
    assign alu_instr   = in_exec ? instr_q : '0;
    assign alu_in1     = in_exec ? rd1 : '0;
    assign alu_in2     = in_exec ? rd2 : '0;
    assign wb_valid    = state_q == WB && !reset;
    assign wb_rd       = wb_valid ? f_rd(instr_q) : 5'd0;
    assign wb_data     = wb_valid ? result_q : '0;
    assign illegal     = illegal_q;

    rtype_regfile #(.XLEN(XLEN)) u_rf (
        .clk       (clk),
        .reset     (reset),
        .ra1       (f_rs1(instr_q)),
        .ra2       (f_rs2(instr_q)),
        .dra       (dbg_raddr),
        .rd1       (rd1),
        .rd2       (rd2),
        .drd       (dbg_rdata),
        .wb_we     (wb_valid),
        .wb_waddr  (f_rd(instr_q)),
        .wb_wdata  (result_q),
        .dbg_we    (dbg_we && state_q == IDLE),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata)
    );

    // sequencing: accept/reject in IDLE, capture result in EXEC, write back in WB
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        if (state_q == IDLE && accept) begin
            instr_d   = (instr_word[6:0] == OPCODE_OP) ? instr_word : instr_q;
            state_d   = (instr_word[6:0] == OPCODE_OP) ? EXEC : IDLE;
            illegal_d = instr_word[6:0] != OPCODE_OP;
        end else if (state_q == EXEC) begin
            result_d = alu_out;
            state_d  = WB;
        end else if (state_q == WB) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers; reset drops any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end
endmodule
